pixel_unpacker: RTL and testbench
=================================

// Module: pixel_unpacker
// PURPOSE
//  Unpacks 128-bit DDR read words into a stream of 24-bit RGB pixels for the VGA frame buffer.
//  Each word carries 5 pixels (5 x 24 = 120 bits); bits [127:120] are pad.
//  Sits between the memory handler read port (rd_data_ordered) and the frame-buffer/BRAM writer, in the ui_clk domain.
//  Inverse of the pixel packer used on the UART->DDR write path.
//  Holds words in a 2-entry buffer so DDR bursts are absorbed while pixels drain one per cycle.
// PARAMETERS
//  PIX_W         24      bits per pixel (R[23:16] G[15:8] B[7:0])
//  PIX_PER_WORD  5       pixels per DDR word
//  WORD_W        128     DDR word width; must be >= PIX_W*PIX_PER_WORD
//  FRAME_PIXELS  786432  pixels per frame (1024x768)
// PORTS
//  clk          in   1       single clock (ui_clk); all logic on rising edge
//  resetn       in   1       asynchronous, active-low reset
//  frame_sync   in   1       synchronous flush: drop buffered words, restart at frame pixel 0
//  word_valid   in   1       word_data valid (ddr_read_ready)
//  word_ready   out  1       buffer can accept a word this cycle
//  word_data    in   WORD_W  packed word; pixel k at [24k+23:24k], k=0 emitted first
//  pix_valid    out  1       pix_data valid
//  pix_ready    in   1       downstream accepts pixel
//  pix_data     out  PIX_W   current pixel
//  pix_last     out  1       qualifies pix_data as last pixel of frame (index FRAME_PIXELS-1)
//  frame_done   out  1       one-cycle pulse the cycle after the last pixel transfers
//  pad_err      out  1       sticky pad-byte error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (resetn=0, async): buffer empty, pix_idx=0, frame_cnt=0.
//    Outputs after reset: word_ready=1, pix_valid=0, pix_last=0, frame_done=0, pad_err=0, pix_data=0.
//  Buffer: 2-entry FIFO of words; occupancy states EMPTY/ONE/FULL.
//    word_ready = (occupancy != FULL).
//    Registered only: no same-cycle bypass. word_ready stays 0 when FULL, even if a pop occurs that cycle.
//  Push: word_valid && word_ready. Latency: a word accepted in cycle N gives pix_valid=1 in cycle N+1.
//  Output:
//    pix_valid = (occupancy != EMPTY).
//    pix_data = head[24*pix_idx +: 24], a combinational mux of registered state.
//    pix_data, pix_valid and pix_last are held stable while pix_valid && !pix_ready.
//  Transfer: pix_valid && pix_ready.
//    pix_idx++ and frame_cnt++.
//    Pop the head word and set pix_idx=0 when pix_idx==PIX_PER_WORD-1, or when pix_last=1.
//  Frame end:
//    pix_last = pix_valid && (frame_cnt==FRAME_PIXELS-1).
//    On transfer of the last pixel, frame_cnt wraps to 0, and the remaining pixels of that word are discarded.
//    Default frame: the 157287th word carries only 2 live pixels.
//    frame_done=1 for exactly the following cycle.
//  Simultaneous push and pop at occupancy ONE: occupancy stays ONE, the new word becomes head next cycle.
//  frame_sync=1: next cycle occupancy=EMPTY, pix_idx=0, frame_cnt=0, pad_err cleared.
//    Overrides any same-cycle push or pop; the word offered that cycle is dropped.
//    No frame_done is generated by a flush.
//  frame_cnt width: $clog2(FRAME_PIXELS); pix_idx width: $clog2(PIX_PER_WORD).
// CONFIGURATION
//  PIXEL_UNPACKER_PAD_CHECK_EN defined:
//    pad_err is set 1 cycle after an accepted word has word_data[127:120] != 0.
//    It stays set until frame_sync or reset.
//  Undefined: pad_err is tied to 0, no check logic is built, and the pad bits are ignored.
// TESTING
//  1 Push word with pixels 0x000001..0x000005, pix_ready=1 -> pix_data 000001..000005 on 5 consecutive cycles starting 1 cycle after push; word_ready stays 1.
//  2 Push 3 words back-to-back with pix_ready=0 -> word_ready=0 after 2nd push; 3rd word held by source; releasing pix_ready drains 15 pixels in order, no loss or duplicate.
//  3 FRAME_PIXELS=7, push 2 words -> pix_last on 7th pixel (word1 pixel 1); word1 pixels 2..4 discarded; frame_done pulses 1 cycle; next word's pixel 0 is frame pixel 0.
//  4 Stall: pix_ready toggles 1010 mid-word -> pix_data stable during stalls, every pixel transferred exactly once.
//  5 Assert frame_sync while FULL and word_valid=1 -> next cycle pix_valid=0, word_ready=1, frame_cnt=0; deassert resetn mid-word -> all outputs at reset values immediately.
//  6 With PIXEL_UNPACKER_PAD_CHECK_EN, push word with [127:120]=0xA5 -> pad_err=1 next cycle, cleared by frame_sync; without the macro -> pad_err stays 0.

Source files
------------

// File: rtl/pixel_unpacker.sv
// Unpacks DDR read words (PIX_PER_WORD x PIX_W pixels, top bits pad) into a pixel stream; PIXEL_UNPACKER_PAD_CHECK_EN builds the sticky pad_err check.
// Latency: a word accepted in cycle N presents its first pixel in cycle N+1.
// Backpressure: 2-word buffer; word_ready drops only while both entries are full, pixel outputs hold while pix_ready is low.
module pixel_unpacker #(
    parameter int PIX_W        = 24,
    parameter int PIX_PER_WORD = 5,
    parameter int WORD_W       = 128,
    parameter int FRAME_PIXELS = 786432
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              frame_sync,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_last,
    output logic              frame_done,
    output logic              pad_err
);

    localparam int CNT_W  = $clog2(FRAME_PIXELS);
    localparam int IDX_W  = $clog2(PIX_PER_WORD);
    localparam int LIVE_W = PIX_W * PIX_PER_WORD;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    occ_t              occ;
    logic [LIVE_W-1:0] head_q;
    logic [LIVE_W-1:0] tail_q;
    logic [IDX_W-1:0]  pix_idx;
    logic [CNT_W-1:0]  frame_cnt;
    logic              push;
    logic              xfer;
    logic              pop;
    logic              last_idx;
    logic [PIX_W-1:0]  head_pix [PIX_PER_WORD];

    assign word_ready = (occ != FULL);
    assign pix_valid  = (occ != EMPTY);
    assign push       = word_valid && word_ready;
    assign xfer       = pix_valid && pix_ready;
    assign pix_last   = pix_valid && (frame_cnt == CNT_W'(FRAME_PIXELS - 1));
    assign last_idx   = (pix_idx == IDX_W'(PIX_PER_WORD - 1));
    // The last pixel of a frame retires the whole word; its remaining pixels are dropped.
    assign pop        = xfer && (last_idx || pix_last);

    for (genvar k = 0; k < PIX_PER_WORD; k++) begin : g_pix
        assign head_pix[k] = head_q[k*PIX_W +: PIX_W];
    end

    assign pix_data = pix_valid ? head_pix[pix_idx] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            occ    <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else if (frame_sync) begin
            occ <= EMPTY;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == EMPTY) head_q <= word_data[LIVE_W-1:0];
                    else              tail_q <= word_data[LIVE_W-1:0];
                    occ <= (occ == EMPTY) ? ONE : FULL;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ    <= (occ == FULL) ? ONE : EMPTY;
                end
                // Push and pop together only happen at ONE: the new word replaces the head.
                2'b11: head_q <= word_data[LIVE_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_idx    <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_sync) begin
                pix_idx   <= '0;
                frame_cnt <= '0;
            end else if (xfer) begin
                pix_idx    <= pop ? '0 : pix_idx + IDX_W'(1);
                frame_cnt  <= pix_last ? '0 : frame_cnt + CNT_W'(1);
                frame_done <= pix_last;
            end
        end
    end

`ifdef PIXEL_UNPACKER_PAD_CHECK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pad_err <= 1'b0;
        end else if (frame_sync) begin
            pad_err <= 1'b0;
        end else if (push && (|word_data[WORD_W-1:LIVE_W])) begin
            pad_err <= 1'b1;
        end
    end
`else
    logic unused_pad_bits;
    assign unused_pad_bits = ^word_data[WORD_W-1:LIVE_W];
    assign pad_err         = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker: default-frame instance plus a 7-pixel-frame instance for frame-end and flush behaviour.
module tb_pixel_unpacker;

    logic         clk;
    logic         resetn;

    logic         fs, wv, wr, pv, pr, pl, fd, pe;
    logic [127:0] wd;
    logic [23:0]  pd;

    logic         fs7, wv7, wr7, pv7, pr7, pl7, fd7, pe7;
    logic [127:0] wd7;
    logic [23:0]  pd7;

    int n_chk;
    int n_fail;

`ifdef PIXEL_UNPACKER_PAD_CHECK_EN
    localparam logic PAD_EXP = 1'b1;
`else
    localparam logic PAD_EXP = 1'b0;
`endif

    pixel_unpacker dut (
        .clk(clk), .resetn(resetn), .frame_sync(fs),
        .word_valid(wv), .word_ready(wr), .word_data(wd),
        .pix_valid(pv), .pix_ready(pr), .pix_data(pd),
        .pix_last(pl), .frame_done(fd), .pad_err(pe)
    );

    pixel_unpacker #(.FRAME_PIXELS(7)) dut7 (
        .clk(clk), .resetn(resetn), .frame_sync(fs7),
        .word_valid(wv7), .word_ready(wr7), .word_data(wd7),
        .pix_valid(pv7), .pix_ready(pr7), .pix_data(pd7),
        .pix_last(pl7), .frame_done(fd7), .pad_err(pe7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mkword(input logic [23:0] base, input logic [7:0] pad);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 5; k++) w[24*k +: 24] = base + 24'(k);
        w[127:120] = pad;
        return w;
    endfunction

    initial begin
        logic [23:0]  got[$];
        logic         got_last[$];
        logic [127:0] q7[$];
        logic [23:0]  t2_base [3];
        logic [23:0]  t3_exp [12];
        logic         accepted;
        logic         prev_last;

        n_chk  = 0;
        n_fail = 0;
        fs = 0; wv = 0; pr = 0; wd = '0;
        fs7 = 0; wv7 = 0; pr7 = 0; wd7 = '0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_word_ready", wr, 1);
        chk("rst_pix_valid", pv, 0);
        chk("rst_pix_last", pl, 0);
        chk("rst_frame_done", fd, 0);
        chk("rst_pad_err", pe, 0);
        chk("rst_pix_data", pd, 0);
        chk("rst_word_ready7", wr7, 1);
        resetn = 1'b1;
        step();

        // Test 1: single word, free-flowing sink
        wd = mkword(24'h000001, 8'h00);
        wv = 1; pr = 1;
        step();
        wv = 0;
        for (int k = 0; k < 5; k++) begin
            chk("t1_valid", pv, 1);
            chk("t1_data", pd, 24'(k + 1));
            chk("t1_word_ready", wr, 1);
            step();
        end
        chk("t1_drained", pv, 0);

        // Test 2: three words against a stalled sink
        t2_base = '{24'h111100, 24'h222200, 24'h333300};
        pr = 0; wv = 1;
        wd = mkword(t2_base[0], 8'h00);
        step();
        wd = mkword(t2_base[1], 8'h00);
        step();
        chk("t2_full_ready", wr, 0);
        wd = mkword(t2_base[2], 8'h00);
        step();
        chk("t2_hold_ready", wr, 0);
        chk("t2_hold_data", pd, 24'h111100);
        pr = 1;
        got.delete();
        for (int c = 0; c < 60 && got.size() < 15; c++) begin
            if (pv) got.push_back(pd);
            accepted = wv && wr;
            step();
            if (accepted) wv = 0;
        end
        chk("t2_count", got.size(), 15);
        chk("t2_third_taken", wv, 0);
        for (int i = 0; i < got.size() && i < 15; i++)
            chk("t2_pixel", got[i], t2_base[i/5] + 24'(i % 5));
        chk("t2_drained", pv, 0);

        // Test 4: 1010 stall pattern mid-word
        wd = mkword(24'h0C0C00, 8'h00);
        wv = 1; pr = 0;
        step();
        wv = 0;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            pr = (c % 2 == 0);
            if (pv && pr) got.push_back(pd);
            else chk("t4_stall_data", pd, 24'h0C0C00 + 24'(got.size()));
            step();
        end
        pr = 0;
        chk("t4_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++)
            chk("t4_pixel", got[i], 24'h0C0C00 + 24'(i));
        chk("t4_drained", pv, 0);

        // Test 5a: flush while FULL with a word on offer (7-pixel frame instance)
        wd7 = mkword(24'h0A0A00, 8'h00);
        wv7 = 1; pr7 = 0;
        step();
        wv7 = 0; pr7 = 1;
        step();
        step();
        pr7 = 0; wv7 = 1;
        wd7 = mkword(24'h0B0B00, 8'h00);
        step();
        chk("t5_full_ready", wr7, 0);
        chk("t5_stall_data", pd7, 24'h0A0A02);
        wd7 = mkword(24'h0E0E00, 8'h00);
        fs7 = 1;
        step();
        fs7 = 0; wv7 = 0;
        chk("t5_flush_valid", pv7, 0);
        chk("t5_flush_ready", wr7, 1);
        chk("t5_flush_last", pl7, 0);
        chk("t5_flush_done", fd7, 0);

        // Test 3: frame end at pixel 6 (word 1 pixel 1); frame count restarts after flush
        t3_exp = '{24'h000100, 24'h000101, 24'h000102, 24'h000103, 24'h000104,
                   24'h000200, 24'h000201,
                   24'h000300, 24'h000301, 24'h000302, 24'h000303, 24'h000304};
        q7.delete();
        q7.push_back(mkword(24'h000100, 8'h00));
        q7.push_back(mkword(24'h000200, 8'h00));
        q7.push_back(mkword(24'h000300, 8'h00));
        got.delete();
        got_last.delete();
        pr7 = 1;
        prev_last = 0;
        for (int c = 0; c < 30; c++) begin
            wv7 = (q7.size() > 0);
            if (wv7) wd7 = q7[0];
            chk("t3_frame_done", fd7, prev_last);
            accepted = wv7 && wr7;
            if (pv7) begin
                got.push_back(pd7);
                got_last.push_back(pl7);
            end
            prev_last = pv7 && pl7;
            step();
            if (accepted) void'(q7.pop_front());
        end
        wv7 = 0; pr7 = 0;
        chk("t3_count", got.size(), 12);
        for (int i = 0; i < got.size() && i < 12; i++) begin
            chk("t3_pixel", got[i], t3_exp[i]);
            chk("t3_last", got_last[i], (i == 6));
        end

        // Test 6: pad byte check and its clear by frame_sync
        wd = mkword(24'h060600, 8'hA5);
        wv = 1; pr = 1;
        step();
        wv = 0;
        chk("t6_pad_err", pe, PAD_EXP);
        fs = 1;
        step();
        fs = 0;
        chk("t6_pad_clear", pe, 0);
        chk("t6_flush_valid", pv, 0);

        // Test 5b: asynchronous reset in the middle of a word
        wd = mkword(24'h0D0D00, 8'h00);
        wv = 1; pr = 1;
        step();
        wv = 0;
        step();
        chk("t5_mid_data", pd, 24'h0D0D01);
        #2 resetn = 1'b0;
        #1;
        chk("t5_arst_valid", pv, 0);
        chk("t5_arst_ready", wr, 1);
        chk("t5_arst_data", pd, 0);
        chk("t5_arst_last", pl, 0);
        chk("t5_arst_done", fd, 0);
        chk("t5_arst_pad", pe, 0);
        step();
        resetn = 1'b1;
        pr = 0;
        step();
        chk("t5_post_valid", pv, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
